instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_fetch                                               |
// | Purpose  : single-outstanding fetch unit with skid, IF/ID register and     |
// |            one-delay-slot redirect handling                                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_if_q, pc_if_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] skid_q, skid_d;
    logic        redir_pending_q, redir_pending_d;
    logic [31:0] redir_target_q, redir_target_d;

    logic        adv;
    logic        src;
    logic [31:0] src_data;
    logic        redir_acc;
    logic [31:0] pc_plus4;
    logic [31:0] redir_tgt;

    assign adv       = en & ~stall;
    assign src       = (state_q == S_FULL) | (imem_req & imem_ack);
    assign src_data  = (state_q == S_FULL) ? skid_q : imem_rdata;
    assign redir_acc = instr_valid_q & adv & (jump_reg | jump_target | jump_branch);
    assign pc_plus4  = pc_q + 32'd4;

    always_comb begin
        redir_tgt = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (jump_reg) begin
            redir_tgt = jr_pc;
        end else if (jump_target) begin
            redir_tgt = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An in-flight response is always taken: into IF/ID when advancing, else into the skid.
    always_comb begin
        state_d = state_q;
        if (adv & src) begin
            state_d = S_IDLE;
        end else if (imem_req & imem_ack) begin
            state_d = S_FULL;
        end else if (imem_req) begin
            state_d = S_WAIT;
        end
    end

    always_comb begin
        imem_req  = (state_q == S_WAIT) | ((state_q == S_IDLE) & en);
        imem_addr = pc_if_q;
    end

    always_comb begin
        pc_if_d         = pc_if_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        instr_valid_d   = instr_valid_q;
        skid_d          = skid_q;
        redir_pending_d = redir_pending_q;
        redir_target_d  = redir_target_q;
        if (adv) begin
            if (src) begin
                pc_d            = pc_if_q;
                instr_d         = src_data;
                instr_valid_d   = 1'b1;
                redir_pending_d = 1'b0;
                if (redir_pending_q) begin
                    pc_if_d = redir_target_q;
                end else if (redir_acc) begin
                    pc_if_d = redir_tgt;
                end else begin
                    pc_if_d = pc_if_q + 32'd4;
                end
            end else begin
                instr_d       = 32'h0;
                instr_valid_d = 1'b0;
                // Delay slot not yet fetched: remember where to go once it arrives.
                if (redir_acc) begin
                    redir_pending_d = 1'b1;
                    redir_target_d  = redir_tgt;
                end
            end
        end else if (imem_req & imem_ack) begin
            skid_d = imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_if_q         <= RESET_PC;
            pc_q            <= 32'h0;
            instr_q         <= 32'h0;
            instr_valid_q   <= 1'b0;
            skid_q          <= 32'h0;
            redir_pending_q <= 1'b0;
            redir_target_q  <= 32'h0;
        end else begin
            pc_if_q         <= pc_if_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            instr_valid_q   <= instr_valid_d;
            skid_q          <= skid_d;
            redir_pending_q <= redir_pending_d;
            redir_target_q  <= redir_target_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// Directed bench for instruction_fetch: the bench plays decode and a small
// instruction memory with either zero-wait or manually timed acknowledges.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        stall;
    logic        jump_branch;
    logic        jump_target;
    logic        jump_reg;
    logic [31:0] jr_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;

    logic        ack_zw;
    logic        ack_man;
    int          total;
    int          bad;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .stall      (stall),
        .jump_branch(jump_branch),
        .jump_target(jump_target),
        .jump_reg   (jump_reg),
        .jr_pc      (jr_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack = ack_zw ? imem_req : ack_man;

    // 0x100 holds a branch with offset -1 word; 0x1000_0000 a J with index 0x10.
    always_comb begin
        case (imem_addr)
            32'h0000_0100: imem_rdata = 32'h1000_FFFF;
            32'h1000_0000: imem_rdata = 32'h0800_0010;
            default:       imem_rdata = imem_addr ^ 32'hDEAD_0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0; en = 1'b0; stall = 1'b0;
        jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0; jr_pc = 32'h0;
        ack_zw = 1'b1; ack_man = 1'b0;

        #3;
        check("rst_pc",    pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_req",   {31'h0, imem_req}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);

        // Zero-wait streaming
        tick();
        rst_n = 1'b1; en = 1'b1;
        #1;
        check("first_req",  {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zw_pc",    pc, 32'(4 * i));
            check("zw_instr", instr, 32'(4 * i) ^ 32'hDEAD_0000);
            check("zw_valid", {31'h0, instr_valid}, 32'h1);
            check("zw_addr",  imem_addr, 32'(4 * i + 4));
        end

        // Ack under stall lands in the skid
        ack_zw = 1'b0;
        tick();
        check("bub_valid", {31'h0, instr_valid}, 32'h0);
        check("bub_instr", instr, 32'h0);
        check("bub_pc",    pc, 32'h0000_000C);
        check("wait_req",  {31'h0, imem_req}, 32'h1);
        stall = 1'b1; ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("full_req",   {31'h0, imem_req}, 32'h0);
        check("full_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("full_hold_req", {31'h0, imem_req}, 32'h0);
        stall = 1'b0;
        tick();
        check("skid_pc",    pc, 32'h0000_0010);
        check("skid_instr", instr, 32'hDEAD_0010);
        check("skid_valid", {31'h0, instr_valid}, 32'h1);
        check("skid_next",  imem_addr, 32'h0000_0014);
        check("skid_req",   {31'h0, imem_req}, 32'h1);

        // Register jump to 0x100, then BEQ at 0x100 back to itself
        ack_zw = 1'b1; jump_reg = 1'b1; jr_pc = 32'h0000_0100;
        tick();
        jump_reg = 1'b0;
        check("jr_slot_pc", pc, 32'h0000_0014);
        check("jr_addr",    imem_addr, 32'h0000_0100);
        tick();
        check("beq_pc", pc, 32'h0000_0100);
        jump_branch = 1'b1;
        tick();
        jump_branch = 1'b0;
        check("beq_slot_pc",    pc, 32'h0000_0104);
        check("beq_slot_instr", instr, 32'hDEAD_0104);
        check("beq_addr",       imem_addr, 32'h0000_0100);
        tick();
        check("beq_tgt_pc", pc, 32'h0000_0100);

        // Register jump while the delay slot waits three cycles
        ack_zw = 1'b0; ack_man = 1'b0; jump_reg = 1'b1; jr_pc = 32'h0000_2000;
        tick();
        jump_reg = 1'b0;
        check("pend_valid0", {31'h0, instr_valid}, 32'h0);
        check("pend_addr0",  imem_addr, 32'h0000_0104);
        tick();
        check("pend_valid1", {31'h0, instr_valid}, 32'h0);
        tick();
        check("pend_pc2", pc, 32'h0000_0100);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("pend_slot_pc",    pc, 32'h0000_0104);
        check("pend_slot_valid", {31'h0, instr_valid}, 32'h1);
        check("pend_addr",       imem_addr, 32'h0000_2000);
        ack_zw = 1'b1;
        tick();
        check("pend_tgt_pc",    pc, 32'h0000_2000);
        check("pend_tgt_instr", instr, 32'hDEAD_2000);
        check("pend_cleared",   imem_addr, 32'h0000_2004);

        // J-type target
        jump_reg = 1'b1; jr_pc = 32'h1000_0000;
        tick();
        jump_reg = 1'b0;
        tick();
        check("j_pc", pc, 32'h1000_0000);
        jump_target = 1'b1;
        tick();
        jump_target = 1'b0;
        check("j_slot_pc", pc, 32'h1000_0004);
        check("j_addr",    imem_addr, 32'h1000_0040);
        tick();
        check("j_tgt_pc",    pc, 32'h1000_0040);
        check("j_tgt_instr", instr, 32'hCEAD_0040);

        // jump_reg outranks jump_branch
        jump_reg = 1'b1; jump_branch = 1'b1; jr_pc = 32'h0000_0300;
        tick();
        jump_reg = 1'b0; jump_branch = 1'b0;
        check("prio_addr", imem_addr, 32'h0000_0300);

        // en low does not abort an outstanding request
        ack_zw = 1'b0; ack_man = 1'b0;
        tick();
        en = 1'b0;
        #1;
        check("en0_req", {31'h0, imem_req}, 32'h1);
        tick();
        check("en0_hold_req", {31'h0, imem_req}, 32'h1);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("en0_full_req", {31'h0, imem_req}, 32'h0);
        en = 1'b1;
        tick();
        check("en0_pc",    pc, 32'h0000_0300);
        check("en0_instr", instr, 32'hDEAD_0300);

        // Reset in the middle of a request, late ack ignored
        tick();
        check("prerst_req", {31'h0, imem_req}, 32'h1);
        en = 1'b0; rst_n = 1'b0;
        #1;
        check("arst_pc",    pc, 32'h0);
        check("arst_instr", instr, 32'h0);
        check("arst_addr",  imem_addr, 32'h0);
        check("arst_req",   {31'h0, imem_req}, 32'h0);
        ack_man = 1'b1;
        tick();
        check("rst_ack_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_ack_req",   {31'h0, imem_req}, 32'h0);
        ack_man = 1'b0; rst_n = 1'b1; en = 1'b1;
        #1;
        check("post_req",  {31'h0, imem_req}, 32'h1);
        check("post_addr", imem_addr, 32'h0);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("post_pc",    pc, 32'h0);
        check("post_instr", instr, 32'hDEAD_0000);
        check("post_valid", {31'h0, instr_valid}, 32'h1);
        check("post_addr4", imem_addr, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
